// File: rtl/cskip_sub_seq.sv
// Sequential carry-skip subtractor: A - B computed one 4-bit group per clock as A + ~B + 1.
// Valid/ready handshake on both operand and result sides.
module cskip_sub_seq #(
   parameter  int unsigned WIDTH   = 10,
   localparam int unsigned NGROUPS = (WIDTH + 3) / 4,
   localparam int unsigned SW      = $clog2(NGROUPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_sub_term1,
   input  logic [WIDTH-1:0] i_sub_term2,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow,
   output logic [SW-1:0]    o_skip_cnt,
   output logic             o_valid,
   input  logic             i_ready
);

   localparam int unsigned PW        = NGROUPS * 4;
   localparam int unsigned GW        = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
   localparam int unsigned LAST_BITS = WIDTH - 4 * (NGROUPS - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [PW-1:0]   a_reg;
   logic [PW-1:0]   b_reg;
   logic [GW-1:0]   grp;
   logic            carry;

   logic [3:0]      a_g_c;
   logic [3:0]      nb_g_c;
   logic [3:0]      s_g_c;
   logic            p_g_c;
   logic            ripple_c;
   logic            cout_c;
   logic            c_top_c;
   logic            last_c;

   // Current group: ripple chain, group propagate and skip mux
   always_comb begin
      a_g_c    = a_reg[4*int'(grp) +: 4];
      nb_g_c   = ~b_reg[4*int'(grp) +: 4];
      s_g_c    = '0;
      c_top_c  = 1'b0;
      ripple_c = carry;
      for (int i = 0; i < 4; i++) begin
         s_g_c[i] = a_g_c[i] ^ nb_g_c[i] ^ ripple_c;
         ripple_c = (a_g_c[i] & nb_g_c[i]) | ((a_g_c[i] ^ nb_g_c[i]) & ripple_c);
         // carry out of bit WIDTH-1 when this is the (possibly partial) last group
         if (i == int'(LAST_BITS) - 1) c_top_c = ripple_c;
      end
      p_g_c  = &(a_g_c ^ nb_g_c);
      cout_c = p_g_c ? carry : ripple_c;
      last_c = (grp == GW'(NGROUPS - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         o_ready    <= 1'b1;
         o_valid    <= 1'b0;
         o_diff     <= '0;
         o_borrow   <= 1'b0;
         o_skip_cnt <= '0;
         grp        <= '0;
         carry      <= 1'b1;
         a_reg      <= '0;
         b_reg      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid && o_ready) begin
                  a_reg      <= PW'(i_sub_term1);
                  b_reg      <= PW'(i_sub_term2);
                  o_diff     <= '0;
                  o_skip_cnt <= '0;
                  carry      <= 1'b1;
                  grp        <= '0;
                  o_ready    <= 1'b0;
                  state      <= CALC;
               end
            end
            CALC: begin
               // padding positions above WIDTH-1 are never written
               for (int i = 0; i < 4; i++) begin
                  if (4*int'(grp) + i < int'(WIDTH)) o_diff[4*int'(grp) + i] <= s_g_c[i];
               end
               if (p_g_c) o_skip_cnt <= o_skip_cnt + SW'(1);
               carry <= cout_c;
               if (last_c) begin
                  o_borrow <= ~c_top_c;
                  o_valid  <= 1'b1;
                  state    <= DONE;
               end else begin
                  grp <= grp + GW'(1);
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
